oam_dma_controller: RTL

- Sequences the sprite-DMA transfer started by a CPU write to $4014.
- Halts the CPU via RDY, then copies 256 bytes from CPU address space page $XX00–$XXFF into the PPU's OAMDATA register, one byte per read/write CPU-cycle pair.
- Sits between the CPU bus, the CPU memory map and the PPU register port.
- It is the only block besides the CPU that drives PPU register writes.

---
 rtl/oam_dma_controller.sv | 130 +++++++++++++
 1 files changed

// File: rtl/oam_dma_controller.sv
// Sprite DMA sequencer: a write to DMA_REG_ADDR halts the CPU and copies one 256-byte page into OAMDATA.
// Every state and output advances only on cpu_ce; each byte takes one READ then one WRITE CPU cycle.
module oam_dma_controller #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [2:0]  OAMDATA_SEL  = 3'h4,
  parameter bit          ALIGN_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_data,
  input  logic [7:0]  mem_data_in,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        ppu_cs_n,
  output logic [2:0]  ppu_address,
  output logic        ppu_rw,
  output logic [7:0]  ppu_data_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t      state_q;
  logic [7:0]  page_q;
  logic [7:0]  idx_q;
  logic [7:0]  idx_d;
  logic        parity_q;
  logic        cpu_rdy_q;
  logic        dma_active_q;
  logic [15:0] mem_addr_q;
  logic        mem_rd_q;
  logic        ppu_cs_n_q;
  logic [2:0]  ppu_address_q;
  logic        ppu_rw_q;
  logic [7:0]  ppu_data_out_q;

  // 8-bit increment keeps the source inside the selected page.
  assign idx_d = idx_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      page_q         <= 8'h00;
      idx_q          <= 8'h00;
      parity_q       <= 1'b0;
      cpu_rdy_q      <= 1'b1;
      dma_active_q   <= 1'b0;
      mem_addr_q     <= 16'h0000;
      mem_rd_q       <= 1'b0;
      ppu_cs_n_q     <= 1'b1;
      ppu_address_q  <= 3'h0;
      ppu_rw_q       <= 1'b0;
      ppu_data_out_q <= 8'h00;
    end else if (cpu_ce) begin
      parity_q <= ~parity_q;
      case (state_q)
        IDLE: begin
          if (cpu_wr && (cpu_addr == DMA_REG_ADDR)) begin
            page_q       <= cpu_data;
            idx_q        <= 8'h00;
            state_q      <= HALT;
            cpu_rdy_q    <= 1'b0;
            dma_active_q <= 1'b1;
          end
        end
        HALT: begin
          if (ALIGN_EN && parity_q) begin
            state_q <= ALIGN;
          end else begin
            state_q    <= READ;
            mem_addr_q <= {page_q, idx_q};
            mem_rd_q   <= 1'b1;
            ppu_cs_n_q <= 1'b1;
          end
        end
        ALIGN: begin
          state_q    <= READ;
          mem_addr_q <= {page_q, idx_q};
          mem_rd_q   <= 1'b1;
          ppu_cs_n_q <= 1'b1;
        end
        READ: begin
          state_q        <= WRITE;
          ppu_data_out_q <= mem_data_in;
          mem_rd_q       <= 1'b0;
          ppu_cs_n_q     <= 1'b0;
          ppu_address_q  <= OAMDATA_SEL;
          ppu_rw_q       <= 1'b1;
        end
        WRITE: begin
          if (idx_q == 8'hFF) begin
            state_q       <= IDLE;
            cpu_rdy_q     <= 1'b1;
            dma_active_q  <= 1'b0;
            ppu_cs_n_q    <= 1'b1;
            ppu_rw_q      <= 1'b0;
            ppu_address_q <= 3'h0;
          end else begin
            state_q    <= READ;
            idx_q      <= idx_d;
            mem_addr_q <= {page_q, idx_d};
            mem_rd_q   <= 1'b1;
            ppu_cs_n_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_rdy      = cpu_rdy_q;
  assign dma_active   = dma_active_q;
  assign mem_addr     = mem_addr_q;
  assign mem_rd       = mem_rd_q;
  assign ppu_cs_n     = ppu_cs_n_q;
  assign ppu_address  = ppu_address_q;
  assign ppu_rw       = ppu_rw_q;
  assign ppu_data_out = ppu_data_out_q;

endmodule
